seq_detect: RTL and testbench

Serial pattern detector placed directly downstream of the serial shift register stage. It accepts one bit per enabled cycle, keeps a sliding window of the last `depth` bits, and emits a one-cycle `match` pulse whenever the window equals the `pattern` parameter. An internal fill phase suppresses matches until `depth` real bits have arrived, so bits left over from reset never produce a false match. An optional saturating match counter feeds the board display.

---
 rtl/seq_detect_pkg.sv | 14 +
 rtl/bit_window.sv | 28 ++
 rtl/seq_detect.sv | 93 +++++++++
 tb/tb_seq_detect.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_detect_pkg.sv
// Shared types and helpers for the seq_detect serial pattern detector.
package seq_detect_pkg;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Width of the fill counter that tracks bits accepted during FILL.
  function automatic int fill_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/bit_window.sv
// Sliding shift window: newest bit enters at the MSB on each enabled cycle.
module bit_window #(
  parameter int depth = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             en,
  input  logic             seq_in,
  output logic [depth-1:0] window
);

  logic [depth-1:0] r_window;

  // NOTE: clear is tested before en so a bit arriving with clear is dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_window <= '0;
    end else if (clear) begin
      r_window <= '0;
    end else if (en) begin
      r_window <= {seq_in, r_window[depth-1:1]};
    end
  end

  assign window = r_window;

endmodule

// File: rtl/seq_detect.sv
// Serial pattern detector with fill guard and registered one-cycle match pulse.
// Optional saturating match counter is built when SEQ_DETECT_COUNT_EN is defined.
module seq_detect
  import seq_detect_pkg::*;
#(
  parameter int               depth   = 4,
  parameter logic [depth-1:0] pattern = depth'(4'b1011),
  parameter int               count_w = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clear,
  input  logic               en,
  input  logic               seq_in,
  output logic [depth-1:0]   window,
  output logic               window_valid,
  output logic               match,
  output logic [count_w-1:0] match_count
);

  localparam int               FW        = fill_w(depth);
  localparam logic [FW-1:0]    FILL_LAST = FW'(depth - 1);

  logic [depth-1:0] w_window;
  logic [depth-1:0] w_next_window;
  logic             w_full_next;
  logic             w_match_next;

  state_t           r_state;
  logic [FW-1:0]    r_fill;
  logic             r_match;

  bit_window #(
    .depth (depth)
  ) u_bit_window (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear),
    .en      (en),
    .seq_in  (seq_in),
    .window  (w_window)
  );

  // NOTE: match is judged on the value the window is about to take, so the
  // registered pulse appears on the same edge as the updated window.
  assign w_next_window = {seq_in, w_window[depth-1:1]};
  assign w_full_next   = (r_state == RUN) || (r_fill == FILL_LAST);
  assign w_match_next  = en && w_full_next && (w_next_window == pattern);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= FILL;
      r_fill  <= '0;
      r_match <= 1'b0;
    end else if (clear) begin
      r_state <= FILL;
      r_fill  <= '0;
      r_match <= 1'b0;
    end else begin
      r_match <= w_match_next;
      if (en && (r_state == FILL)) begin
        if (r_fill == FILL_LAST) begin
          r_state <= RUN;
        end else begin
          r_fill <= r_fill + 1'b1;
        end
      end
    end
  end

`ifdef SEQ_DETECT_COUNT_EN
  logic [count_w-1:0] r_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (w_match_next && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign match_count = r_count;
`else
  assign match_count = '0;
`endif

  assign window       = w_window;
  assign window_valid = (r_state == RUN);
  assign match        = r_match;

endmodule

// File: tb/tb_seq_detect.sv
// Directed bench for seq_detect: vector table plus hand-written corner sequences.
module tb_seq_detect;

`ifdef SEQ_DETECT_COUNT_EN
  localparam bit COUNT_EN = 1'b1;
`else
  localparam bit COUNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic clear = 1'b0;
  logic en = 1'b0;
  logic seq_in = 1'b0;

  logic [3:0] dut_window, sat_window, zero_window;
  logic       dut_valid, sat_valid, zero_valid;
  logic       dut_match, sat_match, zero_match;
  logic [7:0] dut_count, zero_count;
  logic [1:0] sat_count;

  int checks = 0;
  int failures = 0;
  int exp_dut_cnt = 0;
  int exp_sat_cnt = 0;

  always #5 clk = ~clk;

  seq_detect #(.depth(4), .pattern(4'b1011), .count_w(8)) u_dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .en(en), .seq_in(seq_in),
    .window(dut_window), .window_valid(dut_valid), .match(dut_match), .match_count(dut_count)
  );

  seq_detect #(.depth(4), .pattern(4'b1011), .count_w(2)) u_sat (
    .clk(clk), .reset_n(reset_n), .clear(clear), .en(en), .seq_in(seq_in),
    .window(sat_window), .window_valid(sat_valid), .match(sat_match), .match_count(sat_count)
  );

  seq_detect #(.depth(4), .pattern(4'b0000), .count_w(8)) u_zero (
    .clk(clk), .reset_n(reset_n), .clear(clear), .en(en), .seq_in(seq_in),
    .window(zero_window), .window_valid(zero_valid), .match(zero_match), .match_count(zero_count)
  );

  typedef struct {
    logic       clr;
    logic       en;
    logic       b;
    logic [3:0] win;
    logic       valid;
    logic       match;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int bump(input int cnt, input int max_val);
    if (!COUNT_EN) return 0;
    return (cnt < max_val) ? cnt + 1 : cnt;
  endfunction

  // Called at a falling edge: drive inputs, let one rising edge pass, return
  // at the next falling edge where outputs are sampled.
  task automatic step(input logic c, input logic e, input logic b);
    clear  = c;
    en     = e;
    seq_in = b;
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] sat_bits;
    int          sat_exp[5];
    int          m;
    int          k;

    vecs[0]  = '{1'b0, 1'b1, 1'b1, 4'b1000, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 4'b1100, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 4'b1100, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 4'b0110, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 4'b1011, 1'b1, 1'b1};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 4'b1101, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 4'b0110, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 4'b1011, 1'b1, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 4'b1101, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 4'b0110, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 4'b1011, 1'b1, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 4'b1011, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 1'b1, 4'b1000, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 1'b1, 4'b1100, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 1'b1, 1'b0, 4'b0110, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 1'b1, 1'b1, 4'b1011, 1'b1, 1'b1};

    // Reset held for 3 cycles, then released.
    repeat (3) @(negedge clk);
    check("reset_window", 32'(dut_window), 32'h0);
    check("reset_valid",  32'(dut_valid),  32'h0);
    check("reset_match",  32'(dut_match),  32'h0);
    check("reset_count",  32'(dut_count),  32'h0);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_reset_window", 32'(dut_window), 32'h0);
    check("post_reset_valid",  32'(dut_valid),  32'h0);

    // Single match, overlap, idle hold, clear in RUN and refill.
    for (int i = 0; i < 17; i++) begin
      step(vecs[i].clr, vecs[i].en, vecs[i].b);
      if (vecs[i].clr) begin
        exp_dut_cnt = 0;
        exp_sat_cnt = 0;
      end
      if (vecs[i].match) begin
        exp_dut_cnt = bump(exp_dut_cnt, 255);
        exp_sat_cnt = bump(exp_sat_cnt, 3);
      end
      check($sformatf("vec%0d_window", i), 32'(dut_window), 32'(vecs[i].win));
      check($sformatf("vec%0d_valid", i),  32'(dut_valid),  32'(vecs[i].valid));
      check($sformatf("vec%0d_match", i),  32'(dut_match),  32'(vecs[i].match));
      check($sformatf("vec%0d_count", i),  32'(dut_count),  32'(exp_dut_cnt));
      check($sformatf("vec%0d_satcnt", i), 32'(sat_count),  32'(exp_sat_cnt));
    end

    // Saturation: five overlapping matches on the 2-bit counter.
    step(1'b1, 1'b0, 1'b0);
    sat_bits = 16'hDB6D;
    sat_exp  = '{1, 2, 3, 3, 3};
    m = 0;
    for (int i = 15; i >= 0; i--) begin
      step(1'b0, 1'b1, sat_bits[i]);
      k = 16 - i;
      if ((k >= 4) && (((k - 4) % 3) == 0)) begin
        check($sformatf("sat_match_bit%0d", k), 32'(sat_match), 32'h1);
        check($sformatf("sat_count_m%0d", m), 32'(sat_count), COUNT_EN ? 32'(sat_exp[m]) : 32'h0);
        m++;
      end else begin
        check($sformatf("sat_nomatch_bit%0d", k), 32'(sat_match), 32'h0);
      end
    end
    check("sat_window", 32'(sat_window), 32'hB);
    check("sat_valid",  32'(sat_valid),  32'h1);
    check("sat_dut_count", 32'(dut_count), COUNT_EN ? 32'd5 : 32'd0);

    // False-match guard with an all-zero pattern, idle cycles interleaved.
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    check("zero_b1_match", 32'(zero_match), 32'h0);
    step(1'b0, 1'b0, 1'b1);
    check("zero_idle1_match", 32'(zero_match), 32'h0);
    step(1'b0, 1'b1, 1'b0);
    check("zero_b2_match", 32'(zero_match), 32'h0);
    step(1'b0, 1'b0, 1'b1);
    check("zero_idle2_valid", 32'(zero_valid), 32'h0);
    step(1'b0, 1'b1, 1'b0);
    check("zero_b3_match", 32'(zero_match), 32'h0);
    check("zero_b3_valid", 32'(zero_valid), 32'h0);
    step(1'b0, 1'b1, 1'b0);
    check("zero_b4_match", 32'(zero_match), 32'h1);
    check("zero_b4_valid", 32'(zero_valid), 32'h1);
    check("zero_b4_window", 32'(zero_window), 32'h0);
    step(1'b0, 1'b1, 1'b0);
    check("zero_b5_match", 32'(zero_match), 32'h1);
    step(1'b0, 1'b0, 1'b0);
    check("zero_idle3_match", 32'(zero_match), 32'h0);
    check("zero_count", 32'(zero_count), COUNT_EN ? 32'd2 : 32'd0);

    // Clear mid-fill together with an accepted bit: the bit is dropped.
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    check("clr_pre_window", 32'(dut_window), 32'h6);
    step(1'b1, 1'b1, 1'b1);
    check("clr_window", 32'(dut_window), 32'h0);
    check("clr_valid",  32'(dut_valid),  32'h0);
    check("clr_match",  32'(dut_match),  32'h0);
    check("clr_count",  32'(dut_count),  32'h0);
    step(1'b0, 1'b1, 1'b1);
    check("refill1_window", 32'(dut_window), 32'h8);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    check("refill3_valid", 32'(dut_valid), 32'h0);
    step(1'b0, 1'b1, 1'b1);
    check("refill4_window", 32'(dut_window), 32'hB);
    check("refill4_valid",  32'(dut_valid),  32'h1);
    check("refill4_match",  32'(dut_match),  32'h1);

    // Asynchronous reset between clock edges.
    #2;
    reset_n = 1'b0;
    #1;
    check("async_window", 32'(dut_window), 32'h0);
    check("async_valid",  32'(dut_valid),  32'h0);
    check("async_match",  32'(dut_match),  32'h0);
    check("async_count",  32'(dut_count),  32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b0, 1'b1, 1'b1);
    check("post_async_window", 32'(dut_window), 32'h8);
    check("post_async_valid",  32'(dut_valid),  32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
